// File: rtl/flash_boot_loader_if.sv
// rtl/flash_boot_loader_if.sv - flash read, RAM write and status signals of the boot loader
interface flash_boot_loader_if;
  logic        FLASH_RD_REQ;
  logic [23:0] FLASH_ADDR;
  logic        FLASH_RD_ACK;
  logic [7:0]  FLASH_RDATA;
  logic        RAM_WR_REQ;
  logic [23:0] RAM_ADDR;
  logic [7:0]  RAM_WDATA;
  logic        RAM_WR_ACK;
  logic        BUSY;
  logic        DONE;
  logic [1:0]  REGION;

  modport master (
    output FLASH_RD_REQ, FLASH_ADDR, RAM_WR_REQ, RAM_ADDR, RAM_WDATA, BUSY, DONE, REGION,
    input  FLASH_RD_ACK, FLASH_RDATA, RAM_WR_ACK
  );

  modport slave (
    input  FLASH_RD_REQ, FLASH_ADDR, RAM_WR_REQ, RAM_ADDR, RAM_WDATA, BUSY, DONE, REGION,
    output FLASH_RD_ACK, FLASH_RDATA, RAM_WR_ACK
  );
endinterface

// File: rtl/flash_boot_loader.sv
// rtl/flash_boot_loader.sv - boot-time byte copier from SPI flash regions into PSRAM
module flash_boot_loader #(
  parameter bit          EN_NEXTOR            = 1'b1,
  parameter bit          EN_FM                = 1'b1,
  parameter bit          EN_MEGAROM           = 1'b1,
  parameter logic [23:0] NEXTOR_SIZE          = 24'h020000,
  parameter logic [23:0] FM_SIZE              = 24'h010000,
  parameter logic [23:0] MEGAROM_SIZE         = 24'h200000,
  parameter logic [23:0] FLASH_ADDR_BIOS      = 24'h100000,
  parameter logic [23:0] FLASH_ADDR_BIOS_FM   = FLASH_ADDR_BIOS + 24'h020000,
  parameter logic [23:0] FLASH_ADDR_MEGAROM   = 24'h200000,
  parameter logic [23:0] RAM_ADDR_BIOS_NEXTOR = 24'h7B0000,
  parameter logic [23:0] RAM_ADDR_BIOS_FM     = 24'h7D0000,
  parameter logic [23:0] RAM_ADDR_MEGAROM     = 24'h400000
) (
  input  logic                CLK,
  input  logic                RESET_n,
  input  logic                RESTART,
  flash_boot_loader_if.master bus
);

  localparam logic [2:0] ST_START = 3'd0;
  localparam logic [2:0] ST_SEL   = 3'd1;
  localparam logic [2:0] ST_RD    = 3'd2;
  localparam logic [2:0] ST_WR    = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  logic [2:0]  state;
  logic [1:0]  idx;
  logic [23:0] flash_ptr;
  logic [23:0] ram_ptr;
  logic [23:0] remaining;

  logic        sel_en;
  logic [23:0] sel_size;
  logic [23:0] sel_flash;
  logic [23:0] sel_ram;

  // An ack is only honoured while our own request is up.
  logic flash_ack;
  logic ram_ack;
  assign flash_ack = bus.FLASH_RD_ACK && bus.FLASH_RD_REQ;
  assign ram_ack   = bus.RAM_WR_ACK && bus.RAM_WR_REQ;

  always_comb begin
    sel_en    = 1'b0;
    sel_size  = '0;
    sel_flash = '0;
    sel_ram   = '0;
    case (idx)
      2'd0: begin
        sel_en    = EN_NEXTOR;
        sel_size  = NEXTOR_SIZE;
        sel_flash = FLASH_ADDR_BIOS;
        sel_ram   = RAM_ADDR_BIOS_NEXTOR;
      end
      2'd1: begin
        sel_en    = EN_FM;
        sel_size  = FM_SIZE;
        sel_flash = FLASH_ADDR_BIOS_FM;
        sel_ram   = RAM_ADDR_BIOS_FM;
      end
      2'd2: begin
        sel_en    = EN_MEGAROM;
        sel_size  = MEGAROM_SIZE;
        sel_flash = FLASH_ADDR_MEGAROM;
        sel_ram   = RAM_ADDR_MEGAROM;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state            <= ST_START;
      idx              <= 2'd0;
      flash_ptr        <= '0;
      ram_ptr          <= '0;
      remaining        <= '0;
      bus.FLASH_RD_REQ <= 1'b0;
      bus.FLASH_ADDR   <= '0;
      bus.RAM_WR_REQ   <= 1'b0;
      bus.RAM_ADDR     <= '0;
      bus.RAM_WDATA    <= '0;
      bus.BUSY         <= 1'b1;
      bus.DONE         <= 1'b0;
      bus.REGION       <= 2'd3;
    end else begin
      case (state)
        ST_START: begin
          idx   <= 2'd0;
          state <= ST_SEL;
        end
        ST_SEL: begin
          if (idx == 2'd3) begin
            bus.BUSY   <= 1'b0;
            bus.DONE   <= 1'b1;
            bus.REGION <= 2'd3;
            state      <= ST_FIN;
          end else if (!sel_en || sel_size == '0) begin
            idx <= idx + 2'd1;
          end else begin
            flash_ptr        <= sel_flash;
            ram_ptr          <= sel_ram;
            remaining        <= sel_size;
            bus.REGION       <= idx;
            bus.FLASH_RD_REQ <= 1'b1;
            bus.FLASH_ADDR   <= sel_flash;
            state            <= ST_RD;
          end
        end
        ST_RD: begin
          if (flash_ack) begin
            bus.RAM_WDATA    <= bus.FLASH_RDATA;
            bus.FLASH_RD_REQ <= 1'b0;
            bus.RAM_WR_REQ   <= 1'b1;
            bus.RAM_ADDR     <= ram_ptr;
            state            <= ST_WR;
          end
        end
        ST_WR: begin
          if (ram_ack) begin
            bus.RAM_WR_REQ <= 1'b0;
            flash_ptr      <= flash_ptr + 24'd1;
            ram_ptr        <= ram_ptr + 24'd1;
            remaining      <= remaining - 24'd1;
            if (remaining == 24'd1) begin
              idx        <= idx + 2'd1;
              bus.REGION <= 2'd3;
              state      <= ST_SEL;
            end else begin
              // Next read issues straight from the write ack to keep 2 cycles per byte.
              bus.FLASH_RD_REQ <= 1'b1;
              bus.FLASH_ADDR   <= flash_ptr + 24'd1;
              state            <= ST_RD;
            end
          end
        end
        ST_FIN: begin
          if (RESTART) begin
            bus.BUSY <= 1'b1;
            bus.DONE <= 1'b0;
            state    <= ST_START;
          end
        end
        default: state <= ST_START;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_boot_loader.sv
// tb/tb_flash_boot_loader.sv - randomized self-checking bench for flash_boot_loader
module tb_flash_boot_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic restart [3];
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] seed8 = 8'h00;
  int min_d [3];
  int max_d [3];
  bit spur [3];
  int stab_viol [3];
  int ovl_viol [3];
  int req_seen [3];
  logic [23:0] rd_log [3][$];
  logic [33:0] wr_log [3][$];
  logic [23:0] exp_rd [$];
  logic [33:0] exp_wr [$];
  logic [33:0] saved_wr [$];

  logic        done_s [3];
  logic        busy_s [3];
  logic        freq_s [3];
  logic        rreq_s [3];
  logic [1:0]  region_s [3];
  logic [23:0] faddr_s [3];
  logic [23:0] raddr_s [3];
  logic [7:0]  wdata_s [3];

  function automatic logic [7:0] fdata(input logic [23:0] a);
    return (a[7:0] * 8'd29) ^ a[15:8] ^ a[23:16] ^ seed8;
  endfunction

  function automatic logic [23:0] flash_base(input int r);
    case (r)
      0: return 24'h100000;
      1: return 24'h120000;
      default: return 24'h200000;
    endcase
  endfunction

  function automatic logic [23:0] ram_base(input int r);
    case (r)
      0: return 24'h7B0000;
      1: return 24'h7D0000;
      default: return 24'h400000;
    endcase
  endfunction

  function automatic int reg_size(input int g, input int r);
    if (g == 1) return (r == 0) ? 5 : (r == 1) ? 3 : 6;
    return (r == 0) ? 4 : (r == 1) ? 2 : 3;
  endfunction

  function automatic bit reg_en(input int g, input int r);
    if (g == 2) return 1'b0;
    if (g == 1) return r != 1;
    return 1'b1;
  endfunction

  // Instance 0: sizes 4/2/3 all enabled; 1: sizes 5/3/6 with FM disabled; 2: everything disabled.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    flash_boot_loader_if bi ();
    logic       fack;
    logic       rack;
    logic [7:0] frd;
    assign bi.FLASH_RD_ACK = fack;
    assign bi.FLASH_RDATA  = frd;
    assign bi.RAM_WR_ACK   = rack;
    assign done_s[g]   = bi.DONE;
    assign busy_s[g]   = bi.BUSY;
    assign freq_s[g]   = bi.FLASH_RD_REQ;
    assign rreq_s[g]   = bi.RAM_WR_REQ;
    assign region_s[g] = bi.REGION;
    assign faddr_s[g]  = bi.FLASH_ADDR;
    assign raddr_s[g]  = bi.RAM_ADDR;
    assign wdata_s[g]  = bi.RAM_WDATA;

    flash_boot_loader #(
      .EN_NEXTOR   (bit'(g != 2)),
      .EN_FM       (bit'(g == 0)),
      .EN_MEGAROM  (bit'(g != 2)),
      .NEXTOR_SIZE (g == 1 ? 24'd5 : 24'd4),
      .FM_SIZE     (g == 1 ? 24'd3 : 24'd2),
      .MEGAROM_SIZE(g == 1 ? 24'd6 : 24'd3)
    ) dut (
      .CLK    (clk),
      .RESET_n(rst_n),
      .RESTART(restart[g]),
      .bus    (bi)
    );

    initial begin : rsp
      int fw;
      int rw;
      fack = 1'b0; rack = 1'b0; frd = 8'h00; fw = -1; rw = -1;
      forever begin
        @(posedge clk); #1;
        if (fack) begin
          fack = 1'b0; fw = -1;
        end else if (bi.FLASH_RD_REQ) begin
          if (fw < 0) fw = int'($urandom_range(max_d[g], min_d[g]));
          if (fw == 0) begin
            fack = 1'b1;
            frd  = fdata(bi.FLASH_ADDR);
            rd_log[g].push_back(bi.FLASH_ADDR);
          end else fw--;
        end else begin
          fw = -1;
          if (spur[g] && $urandom_range(3, 0) == 0) begin
            fack = 1'b1;
            frd  = 8'($urandom);
          end
        end
        if (rack) begin
          rack = 1'b0; rw = -1;
        end else if (bi.RAM_WR_REQ) begin
          if (rw < 0) rw = int'($urandom_range(max_d[g], min_d[g]));
          if (rw == 0) begin
            rack = 1'b1;
            wr_log[g].push_back({bi.REGION, bi.RAM_ADDR, bi.RAM_WDATA});
          end else rw--;
        end else begin
          rw = -1;
          if (spur[g] && $urandom_range(3, 0) == 0) rack = 1'b1;
        end
      end
    end

    initial begin : mon
      logic pf, pr;
      logic [23:0] pfa, pra;
      logic [7:0] pwd;
      pf = 1'b0; pr = 1'b0; pfa = '0; pra = '0; pwd = '0;
      forever begin
        @(posedge clk); #1;
        if (bi.FLASH_RD_REQ && pf && bi.FLASH_ADDR !== pfa) stab_viol[g]++;
        if (bi.RAM_WR_REQ && pr && (bi.RAM_ADDR !== pra || bi.RAM_WDATA !== pwd)) stab_viol[g]++;
        if (bi.FLASH_RD_REQ && bi.RAM_WR_REQ) ovl_viol[g]++;
        if (bi.FLASH_RD_REQ || bi.RAM_WR_REQ) req_seen[g]++;
        pf = bi.FLASH_RD_REQ; pr = bi.RAM_WR_REQ;
        pfa = bi.FLASH_ADDR; pra = bi.RAM_ADDR; pwd = bi.RAM_WDATA;
      end
    end
  end

  task automatic clear_logs();
    for (int g = 0; g < 3; g++) begin
      rd_log[g].delete();
      wr_log[g].delete();
      stab_viol[g] = 0;
      ovl_viol[g]  = 0;
      req_seen[g]  = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
  endtask

  task automatic run_to_done(input int g, input int budget, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done_s[g] && cyc < budget);
    if (!done_s[g]) cyc = -1;
  endtask

  task automatic build_exp(input int g);
    exp_rd.delete();
    exp_wr.delete();
    for (int r = 0; r < 3; r++) begin
      if (reg_en(g, r)) begin
        for (int i = 0; i < reg_size(g, r); i++) begin
          logic [1:0]  rr;
          logic [23:0] fa, ra;
          rr = 2'(r);
          fa = flash_base(r) + 24'(i);
          ra = ram_base(r) + 24'(i);
          exp_rd.push_back(fa);
          exp_wr.push_back({rr, ra, fdata(fa)});
        end
      end
    end
  endtask

  task automatic diff_stream(input int g, output int idx, output logic [33:0] got, output logic [33:0] exp);
    idx = -1; got = '0; exp = '0;
    if (wr_log[g].size() != exp_wr.size() || rd_log[g].size() != exp_rd.size()) begin
      idx = 9999;
      got = 34'(wr_log[g].size() * 1000 + rd_log[g].size());
      exp = 34'(exp_wr.size() * 1000 + exp_rd.size());
      return;
    end
    for (int i = 0; i < exp_wr.size(); i++) begin
      if (wr_log[g][i] !== exp_wr[i]) begin
        idx = i; got = wr_log[g][i]; exp = exp_wr[i];
        return;
      end
    end
    for (int i = 0; i < exp_rd.size(); i++) begin
      if (rd_log[g][i] !== exp_rd[i]) begin
        idx = 1000 + i; got = 34'(rd_log[g][i]); exp = 34'(exp_rd[i]);
        return;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      logic [62:0] got;
      got = {busy_s[g], done_s[g], region_s[g], freq_s[g], rreq_s[g], faddr_s[g], raddr_s[g], wdata_s[g]};
      checks++;
      if (got !== {1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 24'h0, 24'h0, 8'h0}) begin
        errors++;
        $display("FAIL reset_state inst=%0d got=%h exp=%h", g, got, {1'b1, 1'b0, 2'd3, 58'h0});
      end
    end
  endtask

  task automatic test_zero_wait();
    int cyc, idx;
    logic [33:0] got, exp;
    seed8 = 8'($urandom);
    min_d[0] = 0; max_d[0] = 0; spur[0] = 1'b0;
    do_reset();
    run_to_done(0, 500, cyc);
    build_exp(0);
    checks++;
    if (cyc !== 5 + 2 * exp_wr.size()) begin
      errors++; $display("FAIL t1_done_cycles got=%0d exp=%0d", cyc, 5 + 2 * exp_wr.size());
    end
    diff_stream(0, idx, got, exp);
    checks++;
    if (idx !== -1) begin
      errors++; $display("FAIL t1_stream idx=%0d got=%h exp=%h", idx, got, exp);
    end
    checks++;
    if ({busy_s[0], done_s[0], region_s[0], freq_s[0], rreq_s[0]} !== 6'b0_1_11_0_0) begin
      errors++; $display("FAIL t1_fin_status got=%b exp=011100", {busy_s[0], done_s[0], region_s[0], freq_s[0], rreq_s[0]});
    end
    checks++;
    if (stab_viol[0] + ovl_viol[0] !== 0) begin
      errors++; $display("FAIL t1_handshake got=%0d exp=0", stab_viol[0] + ovl_viol[0]);
    end
  endtask

  task automatic test_random_delay();
    int cyc, idx;
    logic [33:0] got, exp;
    seed8 = 8'($urandom);
    min_d[1] = 1; max_d[1] = 8;
    do_reset();
    run_to_done(1, 3000, cyc);
    build_exp(1);
    checks++;
    if (cyc < 5 + 4 * exp_wr.size()) begin
      errors++; $display("FAIL t2_done_cycles got=%0d exp>=%0d", cyc, 5 + 4 * exp_wr.size());
    end
    diff_stream(1, idx, got, exp);
    checks++;
    if (idx !== -1) begin
      errors++; $display("FAIL t2_stream idx=%0d got=%h exp=%h", idx, got, exp);
    end
    checks++;
    if (stab_viol[1] !== 0 || ovl_viol[1] !== 0) begin
      errors++; $display("FAIL t2_stable_overlap got=%0d/%0d exp=0/0", stab_viol[1], ovl_viol[1]);
    end
  endtask

  task automatic test_all_disabled();
    int cyc;
    do_reset();
    run_to_done(2, 50, cyc);
    checks++;
    if (cyc !== 5) begin
      errors++; $display("FAIL t3_done_cycles got=%0d exp=5", cyc);
    end
    checks++;
    if (busy_s[2] !== 1'b0) begin
      errors++; $display("FAIL t3_busy got=%b exp=0", busy_s[2]);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (req_seen[2] !== 0 || done_s[2] !== 1'b1) begin
      errors++; $display("FAIL t3_no_req got=%0d,%b exp=0,1", req_seen[2], done_s[2]);
    end
  endtask

  task automatic test_reset_mid_copy();
    int cyc, idx, n;
    logic [33:0] got, exp;
    logic [62:0] st;
    seed8 = 8'($urandom);
    min_d[0] = 1; max_d[0] = 3; spur[0] = 1'b0;
    do_reset();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rreq_s[0] && raddr_s[0] == 24'h400001) && n < 2000);
    checks++;
    if (n >= 2000) begin
      errors++; $display("FAIL t4_reach_region2 got=timeout exp=write_0x400001");
    end
    rst_n = 1'b0;
    #1;
    st = {busy_s[0], done_s[0], region_s[0], freq_s[0], rreq_s[0], faddr_s[0], raddr_s[0], wdata_s[0]};
    checks++;
    if (st !== {1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 24'h0, 24'h0, 8'h0}) begin
      errors++; $display("FAIL t4_async_reset got=%h exp=%h", st, {1'b1, 1'b0, 2'd3, 58'h0});
    end
    repeat (2) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!freq_s[0] && n < 20);
    checks++;
    if (faddr_s[0] !== 24'h100000 || !freq_s[0]) begin
      errors++; $display("FAIL t4_restart_addr got=%h exp=100000", faddr_s[0]);
    end
    run_to_done(0, 2000, cyc);
    build_exp(0);
    diff_stream(0, idx, got, exp);
    checks++;
    if (cyc < 0 || idx !== -1) begin
      errors++; $display("FAIL t4_stream cyc=%0d idx=%0d got=%h exp=%h", cyc, idx, got, exp);
    end
  endtask

  task automatic test_restart();
    int cyc, idx, mism;
    logic [33:0] got, exp;
    seed8 = 8'($urandom);
    min_d[0] = 0; max_d[0] = 0; spur[0] = 1'b0;
    do_reset();
    build_exp(0);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      restart[0] = (cyc == 6 || cyc == 22);
    end while (!done_s[0] && cyc < 500);
    restart[0] = 1'b0;
    checks++;
    if (cyc !== 5 + 2 * exp_wr.size()) begin
      errors++; $display("FAIL t5_busy_restart_ignored got=%0d exp=%0d", cyc, 5 + 2 * exp_wr.size());
    end
    diff_stream(0, idx, got, exp);
    checks++;
    if (idx !== -1) begin
      errors++; $display("FAIL t5_first_stream idx=%0d got=%h exp=%h", idx, got, exp);
    end
    saved_wr = wr_log[0];
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_s[0] !== 1'b1 || busy_s[0] !== 1'b0) begin
      errors++; $display("FAIL t5_fin_entry_restart got=%b%b exp=10", done_s[0], busy_s[0]);
    end
    clear_logs();
    restart[0] = 1'b1;
    @(posedge clk); #1;
    restart[0] = 1'b0;
    checks++;
    if (done_s[0] !== 1'b0 || busy_s[0] !== 1'b1) begin
      errors++; $display("FAIL t5_restart_status got=%b%b exp=01", done_s[0], busy_s[0]);
    end
    run_to_done(0, 500, cyc);
    checks++;
    if (cyc !== 5 + 2 * exp_wr.size()) begin
      errors++; $display("FAIL t5_rerun_cycles got=%0d exp=%0d", cyc, 5 + 2 * exp_wr.size());
    end
    mism = (wr_log[0].size() == saved_wr.size()) ? 0 : 1;
    for (int i = 0; i < wr_log[0].size() && i < saved_wr.size(); i++)
      if (wr_log[0][i] !== saved_wr[i]) mism++;
    checks++;
    if (mism !== 0) begin
      errors++; $display("FAIL t5_identical_stream got=%0d_diffs exp=0", mism);
    end
  endtask

  task automatic test_spurious();
    int cyc, idx;
    logic [33:0] got, exp;
    logic [59:0] snap, now;
    seed8 = 8'($urandom);
    min_d[0] = 0; max_d[0] = 4; spur[0] = 1'b1;
    do_reset();
    run_to_done(0, 3000, cyc);
    build_exp(0);
    diff_stream(0, idx, got, exp);
    checks++;
    if (cyc < 0 || idx !== -1) begin
      errors++; $display("FAIL t6_stream cyc=%0d idx=%0d got=%h exp=%h", cyc, idx, got, exp);
    end
    checks++;
    if (stab_viol[0] !== 0 || ovl_viol[0] !== 0) begin
      errors++; $display("FAIL t6_stable_overlap got=%0d/%0d exp=0/0", stab_viol[0], ovl_viol[0]);
    end
    snap = {done_s[0], busy_s[0], region_s[0], faddr_s[0], raddr_s[0], wdata_s[0]};
    repeat (24) @(posedge clk);
    #1;
    now = {done_s[0], busy_s[0], region_s[0], faddr_s[0], raddr_s[0], wdata_s[0]};
    checks++;
    if (now !== snap || freq_s[0] || rreq_s[0]) begin
      errors++; $display("FAIL t6_idle_acks got=%h exp=%h", now, snap);
    end
    spur[0] = 1'b0;
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      restart[g] = 1'b0;
      min_d[g] = 0; max_d[g] = 0; spur[g] = 1'b0;
      stab_viol[g] = 0; ovl_viol[g] = 0; req_seen[g] = 0;
    end
    test_reset();
    test_zero_wait();
    test_random_delay();
    test_all_disabled();
    test_reset_mid_copy();
    test_restart();
    test_spurious();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
